// File: rtl/system_0_sysid_checker_pkg.sv
// system_0_sysid_checker_pkg: FSM encoding, sysid word addresses and stall-counter width
package system_0_sysid_checker_pkg;
    typedef enum logic [2:0] {IDLE, RD_ID, RD_TS, CHECK, FAIL_TO} state_t;
    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;
    localparam int STALL_W = 16;
endpackage

// File: rtl/system_0_sysid_checker_timeout.sv
// system_0_sysid_checker_timeout: waitrequest stall counter, flags the stall cycle that reaches LIMIT
module system_0_sysid_checker_timeout
    import system_0_sysid_checker_pkg::*;
#(
    parameter int LIMIT = 255
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);
    localparam logic [STALL_W-1:0] LAST = STALL_W'(LIMIT - 1);
    logic [STALL_W-1:0] count;
    assign tc = enable && count == LAST;
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) count <= '0;
        else if (clear) count <= '0;
        else if (enable) count <= count + 1'b1;
endmodule

// File: rtl/system_0_sysid_checker.sv
// system_0_sysid_checker: reads sysid ID/timestamp words over Avalon-MM and compares them
// against the expected build values, with a per-read waitrequest timeout.
module system_0_sysid_checker
    import system_0_sysid_checker_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'h5F71_6F1C,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        av_address,
    output logic        av_read,
    input  logic        av_waitrequest,
    input  logic [31:0] av_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);
    state_t state, state_nx;
    logic auto_pend, in_read, accept, stall_tc;
    assign in_read = state == RD_ID || state == RD_TS;
    assign accept = in_read && !av_waitrequest;
    system_0_sysid_checker_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clock  (clock),
        .reset_n(reset_n),
        .clear  (!in_read || accept),
        .enable (in_read && av_waitrequest),
        .tc     (stall_tc)
    );
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (start || auto_pend) ? RD_ID : IDLE;
            RD_ID:   state_nx = accept ? RD_TS : (stall_tc ? FAIL_TO : RD_ID);
            RD_TS:   state_nx = accept ? CHECK : (stall_tc ? FAIL_TO : RD_TS);
            default: state_nx = IDLE;
        endcase
    end
    // Bus strobes and busy are registered from the next state so they line up with it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            auto_pend  <= AUTO_START;
            av_read    <= 1'b0;
            av_address <= ADDR_ID;
            busy       <= 1'b0;
            done       <= 1'b0;
            id_ok      <= 1'b0;
            ts_ok      <= 1'b0;
            timeout    <= 1'b0;
            id_value   <= '0;
            ts_value   <= '0;
        end else begin
            state      <= state_nx;
            auto_pend  <= 1'b0;
            av_read    <= state_nx == RD_ID || state_nx == RD_TS;
            av_address <= state_nx == RD_TS ? ADDR_TS : ADDR_ID;
            busy       <= state_nx != IDLE;
            if (state == IDLE && state_nx == RD_ID) begin
                done    <= 1'b0;
                id_ok   <= 1'b0;
                ts_ok   <= 1'b0;
                timeout <= 1'b0;
            end
            if (state == RD_ID && accept) id_value <= av_readdata;
            if (state == RD_TS && accept) ts_value <= av_readdata;
            if (state == CHECK) begin
                done  <= 1'b1;
                id_ok <= id_value == EXPECTED_ID;
                ts_ok <= ts_value == EXPECTED_TS;
            end
            if (state == FAIL_TO) begin
                done    <= 1'b1;
                timeout <= 1'b1;
                id_ok   <= 1'b0;
                ts_ok   <= 1'b0;
            end
        end
    end
endmodule
